// File: rtl/scan_pkg.sv
// Shared types and default memory map for the pattern-count sequencer.
package scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_PAT,
        ST_SCAN,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } scan_state_t;

    localparam int DEF_PAT_ADDR   = 6;
    localparam int DEF_RES_ADDR   = 7;
    localparam int DEF_START_ADDR = 32;
    localparam int DEF_END_ADDR   = 95;

endpackage

// File: rtl/nibble_match.sv
// Flags a data word when any PAT_W-wide window (stepping by one bit) equals the pattern.
module nibble_match #(
    parameter int DW    = 8,
    parameter int PAT_W = 4
) (
    input  logic [DW-1:0]    data_byte,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit
);

    localparam int NWIN = DW - PAT_W + 1;

    logic [NWIN-1:0] win_hit;

    generate
        for (genvar gi = 0; gi < NWIN; gi++) begin : g_win
            assign win_hit[gi] = (data_byte[gi +: PAT_W] == pattern);
        end
    endgenerate

    // Multiple windows hitting in one byte still count as a single match.
    assign hit = |win_hit;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Alternate data-memory master: reads a pattern, scans an address window,
// counts bytes containing the pattern and writes the count back.
module pattern_scan_ctrl
    import scan_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int PAT_W      = 4,
    parameter int PAT_ADDR   = DEF_PAT_ADDR,
    parameter int RES_ADDR   = DEF_RES_ADDR,
    parameter int START_ADDR = DEF_START_ADDR,
    parameter int END_ADDR   = DEF_END_ADDR,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init,
    output logic          mem_rd_en,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wr_data,
    input  logic [DW-1:0] mem_rd_data,
    output logic          done,
    output logic [DW-1:0] match_ct,
    output logic [CW-1:0] cycle_ct
);

    localparam logic [AW-1:0] PAT_A   = AW'(PAT_ADDR);
    localparam logic [AW-1:0] RES_A   = AW'(RES_ADDR);
    localparam logic [AW-1:0] START_A = AW'(START_ADDR);
    localparam logic [AW-1:0] END_A   = AW'(END_ADDR);
    localparam logic [DW-1:0] MATCH_MAX = '1;
    localparam logic [CW-1:0] CYC_MAX   = '1;

    scan_state_t      state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             first_q, first_d;
    logic [DW-1:0]    match_q, match_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic             rd_en_q, rd_en_d;
    logic             wr_en_q, wr_en_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;

    logic byte_hit;
    logic compare_en;
    logic busy;

    nibble_match #(
        .DW    (DW),
        .PAT_W (PAT_W)
    ) u_match (
        .data_byte (mem_rd_data),
        .pattern   (pat_q),
        .hit       (byte_hit)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        pat_d      = pat_q;
        first_d    = first_q;
        match_d    = match_q;
        cyc_d      = cyc_q;
        compare_en = 1'b0;
        busy       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                match_d = '0;
                cyc_d   = '0;
                if (!init) begin
                    state_d = ST_RD_PAT;
                end
            end
            ST_RD_PAT: begin
                busy    = 1'b1;
                ptr_d   = START_A;
                first_d = 1'b1;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                busy    = 1'b1;
                ptr_d   = ptr_q + AW'(1);
                first_d = 1'b0;
                // The byte arriving in the first scan cycle is the pattern read.
                if (first_q) begin
                    pat_d = mem_rd_data[PAT_W-1:0];
                end else begin
                    compare_en = 1'b1;
                end
                // Terminate on the compare, so END_A at the top of memory still stops.
                if (ptr_q == END_A) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy       = 1'b1;
                compare_en = 1'b1;
                state_d    = ST_WRITE;
            end
            ST_WRITE: begin
                busy    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (init) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (busy && init) begin
            state_d = ST_IDLE;
        end

        if (compare_en && byte_hit && (match_q != MATCH_MAX)) begin
            match_d = match_q + DW'(1);
        end

        if (busy && (cyc_q != CYC_MAX)) begin
            cyc_d = cyc_q + CW'(1);
        end
    end

    // Memory-port outputs are registered from the next state so they change cleanly on the edge.
    always_comb begin
        rd_en_d = (state_d == ST_RD_PAT) || (state_d == ST_SCAN);
        wr_en_d = (state_d == ST_WRITE);
        wdata_d = '0;
        case (state_d)
            ST_RD_PAT: addr_d = PAT_A;
            ST_SCAN:   addr_d = ptr_d;
            ST_WRITE:  addr_d = RES_A;
            default:   addr_d = '0;
        endcase
        if (state_d == ST_WRITE) begin
            wdata_d = match_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            pat_q   <= '0;
            first_q <= 1'b0;
            match_q <= '0;
            cyc_q   <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pat_q   <= pat_d;
            first_q <= first_d;
            match_q <= match_d;
            cyc_q   <= cyc_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_rd_en   = rd_en_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;
    assign done        = (state_q == ST_DONE);
    assign match_ct    = match_q;
    assign cycle_ct    = cyc_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed and randomized runs of pattern_scan_ctrl against a byte-level counting model.
module tb_pattern_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wr_data;
    logic [7:0]  mem_rd_data = 8'h00;
    logic        done;
    logic [7:0]  match_ct;
    logic [15:0] cycle_ct;

    logic [7:0] mem [256];
    logic [7:0] res_val    = 8'hAA;
    logic [7:0] last_waddr = 8'h00;
    int         writes     = 0;
    int         both_ct    = 0;

    int checks = 0;
    int passes = 0;

    pattern_scan_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init        (init),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .done        (done),
        .match_ct    (match_ct),
        .cycle_ct    (cycle_ct)
    );

    always #5 clk = ~clk;

    // Single-port memory: registered read, writes captured for checking.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        if (mem_wr_en) begin
            writes     <= writes + 1;
            last_waddr <= mem_addr;
            if (mem_addr == 8'd7) res_val <= mem_wr_data;
        end
        if (mem_rd_en && mem_wr_en) both_ct <= both_ct + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_count();
        logic [3:0] pat;
        logic [7:0] b;
        int c;
        bit h;
        pat = mem[6][3:0];
        c = 0;
        for (int a = 32; a <= 95; a++) begin
            b = mem[a];
            h = 0;
            for (int k = 0; k <= 4; k++) begin
                if (((b >> k) & 8'h0F) == {4'h0, pat}) h = 1;
            end
            if (h) c++;
        end
        return (c > 255) ? 255 : c;
    endfunction

    task automatic fill_const(input logic [7:0] v, input logic [7:0] pat);
        for (int a = 0; a < 256; a++) mem[a] = v;
        mem[6] = pat;
    endtask

    task automatic fill_rand();
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_cyc(input string tag, input int n);
        int t = 0;
        while (cycle_ct != 16'(n) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, " reach_cycle"}, 32'(cycle_ct), n);
    endtask

    task automatic run_and_check(input string tag, input int exp);
        int w0 = writes;
        int b0 = both_ct;
        int lat = 0;
        init = 1'b0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        $display("run %s: latency=%0d match_ct=%0d cycle_ct=%0d written=%0d expected=%0d",
                 tag, lat, match_ct, cycle_ct, res_val, exp);
        check({tag, " latency"}, lat, 68);
        check({tag, " done"}, 32'(done), 1);
        check({tag, " cycle_ct"}, 32'(cycle_ct), 67);
        check({tag, " match_ct"}, 32'(match_ct), exp);
        check({tag, " write_count"}, writes - w0, 1);
        check({tag, " write_addr"}, 32'(last_waddr), 7);
        check({tag, " mem7"}, 32'(res_val), exp);
        check({tag, " rd_wr_overlap"}, both_ct - b0, 0);
        init = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check({tag, " done_clear"}, 32'(done), 0);
        check({tag, " cycle_clear"}, 32'(cycle_ct), 0);
    endtask

    initial begin
        int w0;
        logic [7:0] r0;

        rst_n = 1'b0;
        init  = 1'b1;
        fill_const(8'h00, 8'h0D);
        #1;
        check("reset rd_en", 32'(mem_rd_en), 0);
        check("reset wr_en", 32'(mem_wr_en), 0);
        check("reset addr", 32'(mem_addr), 0);
        check("reset wdata", 32'(mem_wr_data), 0);
        check("reset done", 32'(done), 0);
        check("reset match_ct", 32'(match_ct), 0);
        check("reset cycle_ct", 32'(cycle_ct), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle done", 32'(done), 0);
        check("idle rd_en", 32'(mem_rd_en), 0);

        fill_const(8'h00, 8'h0D);
        run_and_check("zeros", 0);

        fill_const(8'h00, 8'h0D);
        for (int a = 32; a <= 95; a++) mem[a] = 8'hD0;
        run_and_check("all_d0", 64);

        fill_const(8'h00, 8'hFD);
        mem[32] = 8'h1A;
        mem[95] = 8'h1A;
        mem[31] = 8'h1A;
        mem[96] = 8'h1A;
        run_and_check("edges", 2);

        fill_const(8'h00, 8'h0D);
        mem[60] = 8'hDD;
        run_and_check("single_dd", 1);

        for (int i = 0; i < 3; i++) begin
            fill_rand();
            run_and_check($sformatf("rand%0d", i), ref_count());
        end

        // Abort mid-scan by raising init.
        fill_rand();
        w0 = writes;
        r0 = res_val;
        init = 1'b0;
        wait_cyc("abort", 30);
        init = 1'b1;
        @(negedge clk);
        check("abort done", 32'(done), 0);
        @(negedge clk);
        check("abort cycle_clear", 32'(cycle_ct), 0);
        check("abort match_clear", 32'(match_ct), 0);
        check("abort rd_en", 32'(mem_rd_en), 0);
        repeat (5) @(negedge clk);
        check("abort no_write", writes - w0, 0);
        check("abort mem7", 32'(res_val), 32'(r0));
        run_and_check("abort_rerun", ref_count());

        // Asynchronous reset mid-scan.
        fill_rand();
        w0 = writes;
        init = 1'b0;
        wait_cyc("rst", 40);
        rst_n = 1'b0;
        #1;
        check("rst rd_en", 32'(mem_rd_en), 0);
        check("rst wr_en", 32'(mem_wr_en), 0);
        check("rst addr", 32'(mem_addr), 0);
        check("rst done", 32'(done), 0);
        check("rst match_ct", 32'(match_ct), 0);
        check("rst cycle_ct", 32'(cycle_ct), 0);
        init = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst no_write", writes - w0, 0);
        run_and_check("rst_rerun", ref_count());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Hardware sequencer for the data-memory pattern-count program. It reads a 4-bit pattern from a fixed data-memory address and scans a fixed address window. It counts the bytes that contain the pattern in any aligned-by-one nibble position, writes the count back to memory, and raises `done`. It sits beside the core as an alternate master on the single-port data memory, and uses the same `init`/`done`/`cycle_ct` contract the program benches already drive.

## Interface
- `AW`, 8: data-memory address width.
- `DW`, 8: data-memory data width.
- `PAT_W`, 4: pattern width; windows per byte = DW-PAT_W+1.
- `PAT_ADDR`, 6: pattern location.
- `RES_ADDR`, 7: result location.
- `START_ADDR`, 32: first scanned address.
- `END_ADDR`, 95: last scanned address, inclusive; END_ADDR ≥ START_ADDR.
- `CW`, 16: `cycle_ct` width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `init` in 1: run control. While 1, the block is held idle. A run starts on the first rising edge at which `init` is sampled 0.
- `mem_rd_en` out 1: read request.
- `mem_wr_en` out 1: write request.
- `mem_addr` out AW: read/write address.
- `mem_wr_data` out DW: write data (match count).
- `mem_rd_data` in DW: read data, valid exactly 1 cycle after the `mem_rd_en` cycle.
- `done` out 1: run complete.
- `match_ct` out DW: running/final match count, saturating.
- `cycle_ct` out CW: busy cycles of current/last run, saturating.

## Operation
- FSM states: IDLE, RD_PAT, SCAN, DRAIN, WRITE, DONE.
- IDLE: all requests 0. `match_ct` is held at 0, but `cycle_ct` and `done` are also cleared whenever `init`=1. On `init`=0, go to RD_PAT.
- RD_PAT: `mem_rd_en`=1, `mem_addr`=PAT_ADDR, then go to SCAN. The scan address pointer is loaded with START_ADDR.
- SCAN: one read per cycle, `mem_addr`=pointer, pointer+1.
  - First SCAN cycle: latch `mem_rd_data[PAT_W-1:0]` as the pattern. Upper bits are ignored.
  - Later SCAN cycles and DRAIN: the returning byte is compared.
  - After issuing END_ADDR, go to DRAIN.
- DRAIN: no request. The last byte is compared. Go to WRITE.
- WRITE: `mem_wr_en`=1, `mem_addr`=RES_ADDR, `mem_wr_data`=`match_ct` including the DRAIN byte. Go to DONE.
- DONE: `done`=1. `match_ct` and `cycle_ct` hold. Stay until `init`=1, then go to IDLE.
- Match rule: a byte counts once if any window `byte[k+PAT_W-1:k]` (k=0..DW-PAT_W) equals the pattern, regardless of how many windows hit.
- Counting:
  - `match_ct` increments by 1 per matching byte and saturates at 2^DW-1.
  - `cycle_ct` increments once per cycle in RD_PAT, SCAN, DRAIN and WRITE, and saturates at 2^CW-1.
- `mem_rd_en` and `mem_wr_en` are never both 1 in the same cycle.
- Abort: `init`=1 in any busy state returns the FSM to IDLE on the next edge. No write is issued and `done` stays 0.

## Timing
- All outputs are registered, or decoded from the state register only.
- Reset values: state IDLE; `mem_rd_en`, `mem_wr_en`, `done`=0; `mem_addr`, `mem_wr_data`, `match_ct`, `cycle_ct`=0.
- Busy length = 1 + N + 1 + 1 cycles, where N=END_ADDR-START_ADDR+1. With defaults: 64 reads, 67 cycles.
- `done` rises on the edge after the WRITE cycle. With defaults, `cycle_ct`=67 when `done`=1.
- Reads are issued back-to-back with no bubbles. The compare pipeline is exactly 1 stage.
- Pointer width is AW. END_ADDR=2^AW-1 must terminate on the compare `pointer==END_ADDR`, never on pointer wrap.
- `rst_n` assertion mid-run clears the block immediately, with no write. Operation resumes on the first edge after deassertion, subject to `init`.
- `init`=1 in the same cycle as WRITE: the write completes this cycle, the next state is IDLE, and `done` never rises.

## Structure
- Shared package `scan_pkg`:
  - FSM state enum `scan_state_t`.
  - Default address constants: PAT_ADDR, RES_ADDR, START_ADDR, END_ADDR.
- Sub-module `nibble_match`: combinational. Inputs `byte` (DW), `pattern` (PAT_W); output `hit`. Parameterised by DW and PAT_W, one instance.
- Top: FSM, pointer, pattern register, counters, memory-port muxing.

## Test plan
- Memory all 0x00, pattern 0x0D → `mem[7]`=0, `done`=1, `cycle_ct`=67, exactly one write.
- All scanned bytes 0xD0, pattern 0x0D → `match_ct`=64 and `mem[7]`=64.
- Boundaries: 0x1A (hit at [4:1]) at 32 and 95, all else 0, `mem[PAT_ADDR]`=0xFD → count 2. This proves the edges are scanned and the pattern's upper bits are ignored.
- Single 0xDD in range, rest 0 → count 1 (a byte counts once).
- `init` raised at busy cycle 30, then lowered → first run issues no write and `mem[7]` is unchanged. Second run completes with the correct count and `cycle_ct`=67.
- `rst_n` pulsed low at busy cycle 40 → all outputs 0 asynchronously and no write. A full run after release passes, matching a reference model over $random data.
